// File: rtl/alu_ctrl_seq_pkg.sv
// rtl/alu_ctrl_seq_pkg.sv - shared op codes, ALU function selects, condition codes and FSM states
package alu_ctrl_seq_pkg;

  localparam int W = 64;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_ORR = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_EOR = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;

  // {op[2:0], A-invert, B-invert}
  localparam logic [4:0] FS_AND     = 5'b00000;
  localparam logic [4:0] FS_ORR     = 5'b00100;
  localparam logic [4:0] FS_ADD     = 5'b01000;
  localparam logic [4:0] FS_EOR     = 5'b01100;
  localparam logic [4:0] FS_SUB     = 5'b01001;
  localparam logic [4:0] FS_LSL     = 5'b10000;
  localparam logic [4:0] FS_LSR     = 5'b10100;
  localparam logic [4:0] FS_ILLEGAL = 5'b11000;

  // LEGv8 B.cond encodings
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Codes 8..15 have no ALU mapping
  function automatic logic op_legal(input logic [3:0] op);
    return !op[3];
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_cond_eval.sv
// rtl/alu_ctrl_seq_cond_eval.sv - B.cond evaluation against the {V,C,N,Z} flag register
module cond_eval
  import alu_ctrl_seq_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond_code,
  output logic       cond_true
);

  logic v, c, n, z;
  assign {v, c, n, z} = flags;

  // Purely combinational decode of the condition code
  always_comb begin
    cond_true = 1'b1;
    case (cond_code)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_HS: cond_true = c;
      COND_LO: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c && !z;
      COND_LS: cond_true = !(c && !z);
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z && (n == v);
      COND_LE: cond_true = !(!z && (n == v));
      COND_AL, COND_NV: cond_true = 1'b1;
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - four-state sequencer driving an external ALU and holding NZCV flags
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_setf,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   alu_fs,
  output logic         alu_c0,
  input  logic [W-1:0] alu_f,
  input  logic [3:0]   alu_status,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_status,
  output logic         rsp_err,
  output logic [3:0]   flags,
  input  logic [3:0]   cond_code,
  output logic         cond_true
);

  state_t       state, state_next;
  logic [3:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         setf_q;
  logic         legal_q;

  assign legal_q   = op_legal(op_q);
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: one pass through DRIVE and CAPTURE, then hold RESP until taken
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (req_valid) state_next = ST_DRIVE;
      ST_DRIVE:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_RESP;
      ST_RESP:    if (rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Request is latched on acceptance so the requester may change its inputs afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      setf_q <= 1'b0;
    end else if (state == ST_IDLE && req_valid) begin
      op_q   <= req_op;
      a_q    <= req_a;
      b_q    <= req_b;
      setf_q <= req_setf;
    end
  end

  // ALU operand/function drive; zero whenever the ALU is not in use
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fs = '0;
    alu_c0 = 1'b0;
    if (state == ST_DRIVE || state == ST_CAPTURE) begin
      alu_a = a_q;
      alu_b = b_q;
      case (op_q)
        OP_AND: alu_fs = FS_AND;
        OP_ORR: alu_fs = FS_ORR;
        OP_ADD: alu_fs = FS_ADD;
        OP_EOR: alu_fs = FS_EOR;
        OP_SUB: begin
          alu_fs = FS_SUB;
          alu_c0 = 1'b1;
        end
        OP_LSL: alu_fs = FS_LSL;
        OP_LSR: alu_fs = FS_LSR;
        OP_MOV: begin
          // MOV is realised as 0 | b
          alu_fs = FS_ORR;
          alu_a  = '0;
        end
        default: begin
          alu_fs = FS_ILLEGAL;
          alu_a  = '0;
          alu_b  = '0;
        end
      endcase
    end
  end

  // Response capture at the end of CAPTURE; illegal ops report a clean zero result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_status <= '0;
      rsp_err    <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      rsp_result <= legal_q ? alu_f : '0;
      rsp_status <= legal_q ? alu_status : 4'b0000;
      rsp_err    <= !legal_q;
    end
  end

  // Architectural flags update only for legal, flag-setting operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags <= 4'b0000;
    else if (state == ST_CAPTURE && setf_q && legal_q) flags <= alu_status;
  end

  cond_eval u_cond_eval (
    .flags     (flags),
    .cond_code (cond_code),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - randomized self-checking bench for alu_ctrl_seq with an external ALU stand-in
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        req_setf;
  logic [63:0] alu_a, alu_b;
  logic [4:0]  alu_fs;
  logic        alu_c0;
  logic [63:0] alu_f;
  logic [3:0]  alu_status;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_status;
  logic        rsp_err;
  logic [3:0]  flags;
  logic [3:0]  cond_code;
  logic        cond_true;

  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] exp_flags = 4'b0000;
  time  last_accept = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_setf   (req_setf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fs     (alu_fs),
    .alu_c0     (alu_c0),
    .alu_f      (alu_f),
    .alu_status (alu_status),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .rsp_err    (rsp_err),
    .flags      (flags),
    .cond_code  (cond_code),
    .cond_true  (cond_true)
  );

  // Stand-in for the external ALU, driven only by the function-select lines
  logic [63:0] x_a, x_b;
  logic [64:0] x_sum;
  logic        x_c, x_v;
  always_comb begin
    x_a   = alu_fs[1] ? ~alu_a : alu_a;
    x_b   = alu_fs[0] ? ~alu_b : alu_b;
    x_sum = {1'b0, x_a} + {1'b0, x_b} + {64'd0, alu_c0};
    x_c   = 1'b0;
    x_v   = 1'b0;
    alu_f = 64'd0;
    case (alu_fs[4:2])
      3'd0: alu_f = x_a & x_b;
      3'd1: alu_f = x_a | x_b;
      3'd2: begin
        alu_f = x_sum[63:0];
        x_c   = x_sum[64];
        x_v   = (x_a[63] == x_b[63]) && (x_sum[63] != x_a[63]);
      end
      3'd3: alu_f = x_a ^ x_b;
      3'd4: alu_f = x_a << x_b[5:0];
      3'd5: alu_f = x_a >> x_b[5:0];
      default: alu_f = 64'd0;
    endcase
    alu_status = {x_v, x_c, alu_f[63], alu_f == 64'd0};
  end

  // Reference: what each op means arithmetically, flags as {V,C,N,Z}
  task automatic ref_op(input logic [3:0] op, input logic [63:0] a, b,
                        output logic [63:0] r, output logic [3:0] s, output logic err);
    logic c, v;
    c = 1'b0; v = 1'b0; err = 1'b0; r = 64'd0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin r = a + b; c = (r < a); v = (a[63] == b[63]) && (r[63] != a[63]); end
      4'd3: r = a ^ b;
      4'd4: begin r = a - b; c = (a >= b); v = (a[63] != b[63]) && (r[63] != a[63]); end
      4'd5: r = a << b[5:0];
      4'd6: r = a >> b[5:0];
      4'd7: r = b;
      default: err = 1'b1;
    endcase
    s = err ? 4'b0000 : {v, c, r[63], r == 64'd0};
  endtask

  // Condition codes come in complementary pairs; 14/15 always hold
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cc);
    logic v, c, n, z, base;
    {v, c, n, z} = f;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cc[3:1] == 3'd7) return 1'b1;
    return cc[0] ? !base : base;
  endfunction

  // One complete transaction starting and ending at a negedge with the DUT idle
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, b, input logic setf, input int hold);
    logic [63:0] er, ea, eb;
    logic [3:0]  es;
    logic        eerr;
    logic [4:0]  efs;
    logic        ec0;
    logic [4:0]  fs_tab [8];
    logic [3:0]  cc;
    fs_tab = '{5'b00000, 5'b00100, 5'b01000, 5'b01100, 5'b01001, 5'b10000, 5'b10100, 5'b00100};
    ref_op(op, a, b, er, es, eerr);
    efs = eerr ? 5'b11000 : fs_tab[op[2:0]];
    ec0 = (op == 4'd4);
    ea  = (eerr || op == 4'd7) ? 64'd0 : a;
    eb  = eerr ? 64'd0 : b;

    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", req_ready); end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_setf = setf;
    @(posedge clk);
    last_accept = $time;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_setf = 1'($urandom);
    for (int k = 0; k < 2; k++) begin
      vectors += 5;
      if (alu_fs !== efs) begin miscompares++; $display("FAIL alu_fs op=%0d: got %b want %b", op, alu_fs, efs); end
      if (alu_c0 !== ec0) begin miscompares++; $display("FAIL alu_c0 op=%0d: got %b want %b", op, alu_c0, ec0); end
      if (alu_a !== ea) begin miscompares++; $display("FAIL alu_a op=%0d: got %h want %h", op, alu_a, ea); end
      if (alu_b !== eb) begin miscompares++; $display("FAIL alu_b op=%0d: got %h want %h", op, alu_b, eb); end
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++; $display("FAIL busy_hs: got valid=%b ready=%b want 0 0", rsp_valid, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!eerr && setf) exp_flags = es;
    cc = 4'($urandom);
    cond_code = cc;
    for (int h = 0; h <= hold; h++) begin
      #1;
      vectors += 7;
      if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rsp_valid op=%0d: got %b want 1", op, rsp_valid); end
      if (rsp_result !== er) begin miscompares++; $display("FAIL rsp_result op=%0d a=%h b=%h: got %h want %h", op, a, b, rsp_result, er); end
      if (rsp_status !== es) begin miscompares++; $display("FAIL rsp_status op=%0d: got %b want %b", op, rsp_status, es); end
      if (rsp_err !== eerr) begin miscompares++; $display("FAIL rsp_err op=%0d: got %b want %b", op, rsp_err, eerr); end
      if (flags !== exp_flags) begin miscompares++; $display("FAIL flags op=%0d: got %b want %b", op, flags, exp_flags); end
      if (req_ready !== 1'b0 || alu_fs !== 5'd0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_c0 !== 1'b0) begin
        miscompares++; $display("FAIL resp_quiet: got ready=%b fs=%b a=%h b=%h c0=%b want all 0", req_ready, alu_fs, alu_a, alu_b, alu_c0);
      end
      if (cond_true !== ref_cond(exp_flags, cc)) begin
        miscompares++; $display("FAIL cond_true cc=%0d flags=%b: got %b want %b", cc, flags, cond_true, ref_cond(exp_flags, cc));
      end
      if (h < hold) begin @(posedge clk); @(negedge clk); end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL rsp_done: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic check_cond(input logic [3:0] cc, input logic want);
    cond_code = cc;
    #1;
    vectors++;
    if (cond_true !== want) begin miscompares++; $display("FAIL cond_%0d: got %b want %b", cc, cond_true, want); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 64'd0; req_b = 64'd0;
    req_setf = 1'b0; rsp_ready = 1'b0; cond_code = 4'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 64'd0 || rsp_status !== 4'd0 || rsp_err !== 1'b0 ||
        flags !== 4'd0 || alu_fs !== 5'd0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_c0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b res=%h st=%b err=%b flags=%b fs=%b want all 0",
               rsp_valid, rsp_result, rsp_status, rsp_err, flags, alu_fs);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
    @(negedge clk);
  endtask

  task automatic test_add_directed;
    run_op(4'd2, 64'd5, 64'd7, 1'b1, 0);
    vectors++;
    if (flags !== 4'b0000) begin miscompares++; $display("FAIL add_flags: got %b want 0000", flags); end
  endtask

  task automatic test_sub_zero;
    run_op(4'd4, 64'd3, 64'd3, 1'b1, 0);
    vectors++;
    if (flags !== 4'b0101) begin miscompares++; $display("FAIL sub_zero_flags: got %b want 0101", flags); end
    check_cond(4'd0, 1'b1);
    check_cond(4'd1, 1'b0);
  endtask

  task automatic test_illegal;
    run_op(4'd9, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1);
    vectors++;
    if (flags !== 4'b0101) begin miscompares++; $display("FAIL illegal_flags: got %b want 0101", flags); end
  endtask

  task automatic test_stall;
    run_op(4'd3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 5);
  endtask

  task automatic test_overflow;
    run_op(4'd4, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
    vectors++;
    if (flags !== 4'b1100) begin miscompares++; $display("FAIL ovf_flags: got %b want 1100", flags); end
    check_cond(4'd10, 1'b0);
    check_cond(4'd11, 1'b1);
  endtask

  task automatic test_cond_sweep;
    for (int i = 0; i < 16; i++) check_cond(4'(i), ref_cond(exp_flags, 4'(i)));
  endtask

  task automatic test_reset_capture;
    req_valid = 1'b1; req_op = 4'd2; req_a = 64'd1; req_b = 64'd1; req_setf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_flags = 4'b0000;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || flags !== 4'd0 || alu_fs !== 5'd0 || alu_a !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_in_capture: got ready=%b valid=%b flags=%b fs=%b a=%h want 1 0 0 0 0",
               req_ready, rsp_valid, flags, alu_fs, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || flags !== 4'd0) begin
        miscompares++; $display("FAIL post_reset_quiet: got valid=%b ready=%b flags=%b want 0 1 0000", rsp_valid, req_ready, flags);
      end
    end
  endtask

  task automatic test_back_to_back;
    time t0;
    run_op(4'd2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      t0 = last_accept;
      run_op(4'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 0);
      vectors++;
      if (last_accept - t0 != 40) begin
        miscompares++; $display("FAIL b2b_spacing: got %0t want 40", last_accept - t0);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3)) << 62;
      run_op(4'($urandom_range(0, 15)), a, b, 1'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset;
    test_add_directed;
    test_sub_zero;
    test_illegal;
    test_stall;
    test_overflow;
    test_cond_sweep;
    test_reset_capture;
    test_back_to_back;
    test_random;
    test_cond_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
